// File: rtl/config_access_sync.sv
// config_access_sync: brings configuration bits into the UserCLK domain, debounces them and
// commits them atomically to the fabric-top outputs with an update strobe (optional pulse bits).
`default_nettype none

module config_access_sync #(
  parameter int                      NoConfigBits  = 4,
  parameter int                      STABLE_CYCLES = 4,
  parameter logic [NoConfigBits-1:0] PULSE_MASK    = '0
) (
  input  logic                    UserCLK,
  input  logic                    resetn,
  input  logic [NoConfigBits-1:0] ConfigBits,
  input  logic                    freeze,
  output logic [NoConfigBits-1:0] C_bits,
  output logic                    C_update,
  output logic                    C_pending
);

  localparam int               CNT_W    = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [NoConfigBits-1:0] r_s1;
  logic [NoConfigBits-1:0] r_s2;
  logic [NoConfigBits-1:0] r_snap;
  logic [NoConfigBits-1:0] w_snap_nxt;
  logic [NoConfigBits-1:0] r_held;
  logic [NoConfigBits-1:0] w_held_nxt;
  logic [NoConfigBits-1:0] r_pulse;
  logic [NoConfigBits-1:0] w_pulse_nxt;
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        w_cnt_nxt;
  logic                    r_update;
  logic                    w_update_nxt;

  // Two-flop synchroniser; only r_s2 is consumed downstream.
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= ConfigBits;
      r_s2 <= r_s1;
    end
  end

  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      r_state  <= ST_IDLE;
      r_snap   <= '0;
      r_held   <= '0;
      r_cnt    <= '0;
      r_update <= 1'b0;
      r_pulse  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_snap   <= w_snap_nxt;
      r_held   <= w_held_nxt;
      r_cnt    <= w_cnt_nxt;
      r_update <= w_update_nxt;
      r_pulse  <= w_pulse_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_snap_nxt   = r_snap;
    w_held_nxt   = r_held;
    w_cnt_nxt    = r_cnt;
    w_update_nxt = 1'b0;
    w_pulse_nxt  = '0;
    case (r_state)
      ST_IDLE: begin
        if (r_s2 != r_held) begin
          w_snap_nxt  = r_s2;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        // A reverted change abandons the commit; a new value restarts the debounce.
        if (r_s2 == r_held) begin
          w_state_nxt = ST_IDLE;
        end else if (r_s2 != r_snap) begin
          w_snap_nxt = r_s2;
          w_cnt_nxt  = '0;
        end else if (r_cnt < CNT_LAST) begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end else if (!freeze) begin
          w_state_nxt = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        w_held_nxt   = r_snap;
        w_update_nxt = 1'b1;
        w_pulse_nxt  = PULSE_MASK & r_snap & ~r_held;
        w_state_nxt  = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign C_bits    = (PULSE_MASK & r_pulse) | (~PULSE_MASK & r_held);
  assign C_update  = r_update;
  assign C_pending = (r_state != ST_IDLE);

endmodule

`default_nettype wire
